// File: rtl/xgmii_rs_rx_fault.sv
// Receive-side RS link-fault monitor: detects local/remote fault sequences,
// reports link status and delivers a fault-cleaned XGMII stream to the MAC.
module xgmii_rs_rx_fault #(
  parameter int COL_WINDOW = 128,
  parameter int SEQ_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pma_sync,
  input  logic [31:0]      rx_data,
  input  logic [3:0]       rx_ctrl,
  input  logic             rx_ena,
  output logic [31:0]      mac_data,
  output logic [3:0]       mac_ctrl,
  output logic             mac_ena,
  output logic [1:0]       link_status,
  output logic [CNT_W-1:0] fault_cnt
);
  localparam int COL_W = $clog2(COL_WINDOW + 1);
  localparam int SEQ_W = $clog2(SEQ_THRESH + 1);
  localparam logic [31:0] IDLE_D   = 32'h0707_0707;
  localparam logic [31:0] ERR_D    = 32'hFEFE_FEFE;
  localparam logic [31:0] LOCAL_D  = 32'h0100_009C;
  localparam logic [31:0] REMOTE_D = 32'h0200_009C;

  typedef enum logic [1:0] {INIT, COUNT, FAULT} state_e;

  state_e           state_q, state_d;
  logic             seq_type_q, seq_type_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d, col_inc;
  logic [1:0]       ls_q, ls_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             in_frame_q, in_frame_d;
  logic             err_pending_q, err_pending_d;
  logic             gate_q, gate_d;
  logic             lost_q;
  logic [31:0]      mac_data_q, data_d;
  logic [3:0]       mac_ctrl_q, ctrl_d;
  logic             mac_ena_q;
  logic             is_local, is_remote, is_fault_seq, seq_t, term_col;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [1:0] type_code(input logic remote);
    return remote ? 2'b10 : 2'b01;
  endfunction

  assign is_local     = (rx_ctrl == 4'b0001) && (rx_data == LOCAL_D);
  assign is_remote    = (rx_ctrl == 4'b0001) && (rx_data == REMOTE_D);
  assign is_fault_seq = is_local | is_remote;
  assign seq_t        = is_remote;
  assign col_inc      = col_cnt_q + COL_W'(1);

  always_comb begin
    term_col = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rx_ctrl[i] && (rx_data[8*i +: 8] == 8'hFD || rx_data[8*i +: 8] == 8'hFE))
        term_col = 1'b1;
    end
  end

  // Sequence qualification FSM; pma_sync loss overrides all of it.
  always_comb begin
    state_d    = state_q;
    seq_type_d = seq_type_q;
    seq_cnt_d  = seq_cnt_q;
    col_cnt_d  = col_cnt_q;
    ls_d       = ls_q;
    if (rx_ena) begin
      if (is_fault_seq) begin
        col_cnt_d = '0;
        if (state_q == INIT || seq_t != seq_type_q) begin
          state_d    = COUNT;
          seq_type_d = seq_t;
          seq_cnt_d  = SEQ_W'(1);
        end else if (state_q == COUNT) begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          if (seq_cnt_q + SEQ_W'(1) == SEQ_W'(SEQ_THRESH)) begin
            state_d = FAULT;
            ls_d    = type_code(seq_t);
          end
        end
      end else if (state_q != INIT) begin
        col_cnt_d = col_inc;
        if (col_inc == COL_W'(COL_WINDOW)) begin
          state_d   = INIT;
          seq_cnt_d = '0;
          col_cnt_d = '0;
          ls_d      = 2'b00;
        end
      end
    end
    if (lost_q) ls_d = 2'b00;
    if (!pma_sync) begin
      state_d   = INIT;
      seq_cnt_d = '0;
      col_cnt_d = '0;
      ls_d      = 2'b01;
    end
  end

  assign fcnt_d = (ls_q == 2'b00 && ls_d != 2'b00) ? sat_inc(fcnt_q) : fcnt_q;

  // Output selection uses the link status held before this column.
  always_comb begin
    data_d        = IDLE_D;
    ctrl_d        = 4'hF;
    in_frame_d    = in_frame_q;
    err_pending_d = err_pending_q;
    gate_d        = gate_q;
    if (rx_ena) begin
      if (rx_ctrl[0] && rx_data[7:0] == 8'hFB) in_frame_d = 1'b1;
      else if (term_col)                       in_frame_d = 1'b0;
      if (!is_fault_seq) begin
        if (err_pending_q) begin
          data_d        = ERR_D;
          err_pending_d = 1'b0;
        end else if (ls_q == 2'b00 && (!gate_q || rx_ctrl == 4'hF)) begin
          data_d = rx_data;
          ctrl_d = rx_ctrl;
          gate_d = 1'b0;
        end
      end
    end
    if (ls_d != 2'b00) gate_d = 1'b1;
    if (ls_q == 2'b00 && ls_d != 2'b00 && in_frame_d) begin
      err_pending_d = 1'b1;
      in_frame_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      seq_type_q    <= 1'b0;
      seq_cnt_q     <= '0;
      col_cnt_q     <= '0;
      ls_q          <= 2'b00;
      fcnt_q        <= '0;
      in_frame_q    <= 1'b0;
      err_pending_q <= 1'b0;
      gate_q        <= 1'b0;
      lost_q        <= 1'b0;
      mac_data_q    <= IDLE_D;
      mac_ctrl_q    <= 4'hF;
      mac_ena_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_type_q    <= seq_type_d;
      seq_cnt_q     <= seq_cnt_d;
      col_cnt_q     <= col_cnt_d;
      ls_q          <= ls_d;
      fcnt_q        <= fcnt_d;
      in_frame_q    <= in_frame_d;
      err_pending_q <= err_pending_d;
      gate_q        <= gate_d;
      lost_q        <= ~pma_sync;
      mac_data_q    <= data_d;
      mac_ctrl_q    <= ctrl_d;
      mac_ena_q     <= rx_ena;
    end
  end

  assign mac_data    = mac_data_q;
  assign mac_ctrl    = mac_ctrl_q;
  assign mac_ena     = mac_ena_q;
  assign link_status = ls_q;
  assign fault_cnt   = fcnt_q;
endmodule
